// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the fifo write arbiter
// and the read-side scheduler that reuses rr_arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int MAX_REQ   = 16;
  localparam int IDX_W     = 4;
  localparam int DEF_DEPTH = 8;
  localparam int OCC_W     = $clog2(DEF_DEPTH + 1);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Walk the search order backwards so the last hit is the first requester
  // after last_idx; avoids a loop break.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [IDX_W-1:0]   last_idx,
                                       input int                 n);
    rr_pick_t         r;
    logic [IDX_W-1:0] j;
    r = '0;
    for (int k = n; k >= 1; k--) begin
      j = IDX_W'((int'(last_idx) + k) % n);
      if (valid[j]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester and fifo write-side bundle; slave is the arbiter's view.
interface fifo_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_w_en;
  logic [WIDTH-1:0]       fifo_write_data;
  logic                   fifo_r_en;
  logic                   fifo_full;
  logic [OW-1:0]          occupancy;
  logic [GW-1:0]          grant_id;
  logic                   busy;

  modport slave (
    input  req_valid, req_data, req_last, fifo_r_en, fifo_full,
    output req_ready, fifo_w_en, fifo_write_data, occupancy, grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_last, fifo_r_en, fifo_full,
    input  req_ready, fifo_w_en, fifo_write_data, occupancy, grant_id, busy
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_arbiter.sv
// Combinational rotate-priority pick: first valid requester after last_i.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [GW-1:0]    last_i,
  output logic             found_o,
  output logic [GW-1:0]    idx_o
);

  rr_pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_REQ'(valid_i), IDX_W'(last_i), N_REQ);
    found_o = pick.found;
    idx_o   = GW'(pick.idx);
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter with burst lock and a credit counter that
// accounts for the registered write stage so the fifo never overflows.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int BURST_MODE = 1
) (
  input logic                 clk,
  input logic                 reset,
  fifo_write_arbiter_if.slave bus
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(N_REQ);

  arb_state_t       state_q;
  logic [OW-1:0]    occ_q, occ_d;
  logic [GW-1:0]    grant_q;
  logic             wen_q;
  logic [WIDTH-1:0] wdata_q;

  logic             can_write, found, xfer, rd_ret;
  logic [GW-1:0]    winner, sel;
  logic [N_REQ-1:0] ready;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .valid_i (bus.req_valid),
    .last_i  (grant_q),
    .found_o (found),
    .idx_o   (winner)
  );

  // A full counter blocks grants even with a read this cycle; the returned
  // credit becomes usable one cycle later, which keeps this path short.
  always_comb begin
    can_write = (occ_q < OW'(DEPTH)) && !bus.fifo_full;
    sel       = (state_q == BURST) ? grant_q : winner;
    ready     = '0;
    if (reset && can_write && ((state_q == BURST) || found)) ready[sel] = 1'b1;
    xfer      = |(ready & bus.req_valid);
    sel_data  = bus.req_data[int'(sel)*WIDTH +: WIDTH];
    rd_ret    = bus.fifo_r_en && (occ_q != '0);
    occ_d     = occ_q + OW'(xfer) - OW'(rd_ret);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      occ_q   <= '0;
      grant_q <= GW'(N_REQ - 1);
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      wen_q <= xfer;
      occ_q <= occ_d;
      if (xfer) wdata_q <= sel_data;
      case (state_q)
        IDLE: if (xfer) begin
          grant_q <= winner;
          if ((BURST_MODE != 0) && !bus.req_last[winner]) state_q <= BURST;
        end
        BURST: if (xfer && bus.req_last[grant_q]) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready       = ready;
  assign bus.fifo_w_en       = wen_q;
  assign bus.fifo_write_data = wdata_q;
  assign bus.occupancy       = occ_q;
  assign bus.grant_id        = grant_q;
  assign bus.busy            = (state_q == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter against a queue-based
// model of the arbitration rules, feeding a behavioural fifo.
module tb_fifo_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) bus ();

  fifo_write_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D), .BURST_MODE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // model state: credit, last grant, locked requester (-1 = none), write stage
  int         m_occ = 0, m_grant = N - 1, m_lock = -1;
  bit         m_wen = 0;
  logic [7:0] m_wdata = '0;
  bit         have_exp = 0;
  logic [7:0] mq[$];
  logic [7:0] fq[$];
  logic [7:0] rd_log[$];

  // decisions sampled mid-cycle, applied at the following rising edge
  bit         n_rst = 1, n_xfer = 0, n_last = 0, n_ren = 0, s_wen = 0;
  int         n_idx = 0;
  logic [7:0] n_data = '0, s_wdata = '0;

  always @(negedge clk) begin
    logic [N-1:0] er;
    bit           can;
    int           w;
    if (have_exp) begin
      chk("w_en", bus.fifo_w_en, m_wen);
      chk("w_data", bus.fifo_write_data, m_wdata);
      chk("occupancy", bus.occupancy, m_occ);
      chk("grant_id", bus.grant_id, m_grant);
      chk("busy", bus.busy, m_lock >= 0);
    end
    er  = '0;
    w   = -1;
    can = (m_occ < D) && !bus.fifo_full;
    if (m_lock >= 0) w = m_lock;
    else
      for (int k = 1; k <= N; k++)
        if (w < 0 && bus.req_valid[(m_grant + k) % N]) w = (m_grant + k) % N;
    if (reset && can && w >= 0) er[w] = 1'b1;
    if (have_exp) chk("req_ready", bus.req_ready, er);
    n_rst  = !reset;
    n_xfer = (w >= 0) && er[w] && bus.req_valid[w];
    n_idx  = w;
    n_data = (w >= 0) ? bus.req_data[w*W +: W] : '0;
    n_last = (w >= 0) ? bus.req_last[w] : 1'b0;
    n_ren  = bus.fifo_r_en;
    s_wen  = bus.fifo_w_en;
    s_wdata = bus.fifo_write_data;
  end

  always @(posedge clk) begin
    logic [7:0] got;
    if (n_rst) begin
      m_occ = 0; m_grant = N - 1; m_lock = -1; m_wen = 0; m_wdata = '0;
      mq.delete(); fq.delete();
      have_exp = 1;
    end else begin
      if (n_ren && fq.size() > 0) begin
        got = fq.pop_front();
        rd_log.push_back(got);
        if (mq.size() == 0) chk("rd_order_empty", got, 32'hFFFF_FFFF);
        else chk("rd_order", got, mq.pop_front());
      end
      if (s_wen) begin
        chk("no_overflow", fq.size() < D, 1);
        if (fq.size() < D) fq.push_back(s_wdata);
      end
      m_wen = n_xfer;
      if (n_xfer) begin
        m_wdata = n_data;
        mq.push_back(n_data);
        m_grant = n_idx;
        if (m_lock >= 0) begin
          if (n_last) m_lock = -1;
        end else if (!n_last) m_lock = n_idx;
      end
      m_occ = m_occ + int'(n_xfer) - int'(n_ren && m_occ > 0);
    end
    bus.fifo_full = (fq.size() == D);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = W'($urandom);
  endtask

  task automatic drain();
    bus.req_valid = '0;
    for (int i = 0; i < 2*D + 2; i++) begin
      bus.fifo_r_en = (fq.size() > 0);
      tick();
    end
    bus.fifo_r_en = 1'b0;
    chk("drain_occ", bus.occupancy, 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b0000;
    bus.req_data  = '0;
    bus.fifo_r_en = 1'b0;

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_wen", bus.fifo_w_en, 0);
      chk("rst_occ", bus.occupancy, 0);
      chk("rst_grant", bus.grant_id, 3);
    end

    // round robin, single-beat bursts
    reset = 1'b1;
    bus.req_last = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      tick();
      chk("rr_grant", bus.grant_id, i % 4);
    end
    chk("rr_occ", bus.occupancy, 8);
    chk("rr_full_ready", bus.req_ready, 0);

    // full stall, one credit returned
    bus.req_valid = 4'b0001;
    rand_data();
    tick();
    chk("stall_ready", bus.req_ready, 0);
    bus.fifo_r_en = 1'b1;
    tick();
    bus.fifo_r_en = 1'b0;
    chk("stall_occ7", bus.occupancy, 7);
    chk("stall_ready0", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    chk("stall_occ8", bus.occupancy, 8);
    drain();

    // burst lock: req1 three beats, req2 waiting
    rd_log.delete();
    bus.req_valid = 4'b0110;
    bus.req_last  = 4'b0100;
    bus.req_data  = 32'h0021_1100;
    tick();
    chk("burst_g1", bus.grant_id, 1);
    chk("burst_b1", bus.busy, 1);
    bus.req_data[15:8] = 8'h12;
    tick();
    chk("burst_g2", bus.grant_id, 1);
    chk("burst_b2", bus.busy, 1);
    bus.req_data[15:8] = 8'h13;
    bus.req_last[1] = 1'b1;
    tick();
    chk("burst_g3", bus.grant_id, 1);
    chk("burst_b3", bus.busy, 0);
    tick();
    chk("burst_g4", bus.grant_id, 2);
    drain();
    chk("burst_cnt", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("burst_w0", rd_log[0], 8'h11);
      chk("burst_w1", rd_log[1], 8'h12);
      chk("burst_w2", rd_log[2], 8'h13);
      chk("burst_w3", rd_log[3], 8'h21);
    end

    // simultaneous read and write at occupancy 4
    bus.req_valid = 4'b1000;
    bus.req_last  = 4'b1111;
    for (int i = 0; i < 4; i++) begin rand_data(); tick(); end
    chk("rw_occ_fill", bus.occupancy, 4);
    bus.fifo_r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      tick();
      chk("rw_occ_hold", bus.occupancy, 4);
    end
    drain();

    // reset in the middle of a burst
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0000;
    tick();
    tick();
    chk("mid_busy_pre", bus.busy, 1);
    reset = 1'b0;
    tick();
    chk("mid_busy", bus.busy, 0);
    chk("mid_occ", bus.occupancy, 0);
    chk("mid_grant", bus.grant_id, 3);
    reset = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    tick();
    chk("mid_first_grant", bus.grant_id, 0);
    drain();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.req_valid = N'($urandom);
      bus.req_last  = N'($urandom);
      rand_data();
      bus.fifo_r_en = (fq.size() > 0) && ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.req_last = 4'b1111;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write port of one fifo instance (DEPTH/LEVEL fifo, 8-bit data) between N_REQ requesters.
- Each requester uses a valid/ready handshake.
- Round-robin arbitration, with optional burst locking via req_last.
- Keeps its own occupancy credit counter so the fifo never overflows, even though write outputs are registered.
- Sits directly in front of the fifo; the fifo read side is driven elsewhere and only observed here.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data width; matches the fifo write_data width.
- DEPTH, 8, fifo capacity in words; must equal the fifo's DEPTH.
- BURST_MODE, 1, 1 = hold the grant until a beat with req_last is accepted; 0 = re-arbitrate every beat.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  N_REQ  per-requester data valid.
- req_data  in  N_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  N_REQ  marks the final beat of a burst.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- fifo_w_en  out  1  registered write enable to the fifo.
- fifo_write_data  out  WIDTH  registered write data to the fifo.
- fifo_r_en  in  1  read enable as driven to the fifo; used to return credit.
- fifo_full  in  1  fifo full flag; safety gate.
- occupancy  out  $clog2(DEPTH+1)  credit count (words written or in flight, minus words read).
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester.
- busy  out  1  high while in the BURST state.

Behaviour:
- Reset (reset==0 at a clock edge):
  - fifo_w_en=0, fifo_write_data=0, occupancy=0, grant_id=N_REQ-1, busy=0, state=IDLE.
  - req_ready is 0 during any cycle in which reset is 0.
  - Reset mid-burst drops the lock. A write accepted in the cycle reset asserts is discarded (fifo_w_en=0 next cycle).
- Credit: can_write = (occupancy < DEPTH) && !fifo_full.
- Beat transfer: req_valid[i] && req_ready[i] at a rising edge.
- req_ready is combinational from state, credit and req_valid. It is never gated on req_ready itself.
- State IDLE:
  - Winner = first i with req_valid[i], searching from (grant_id+1) mod N_REQ upward with wrap.
  - req_ready[winner] = can_write. On transfer, grant_id <= winner.
  - If BURST_MODE and !req_last[winner] on transfer, go to BURST.
  - If no requester is valid or credit is 0, all ready = 0, grant_id holds, no transfer.
- State BURST:
  - Only req_ready[grant_id] may assert, equal to can_write. Other requesters stall regardless of valid.
  - On transfer with req_last[grant_id]=1, go to IDLE.
  - The locked requester deasserting valid keeps the lock; no timeout.
  - busy = (state==BURST).
- Write path latency: a transfer at edge t sets fifo_w_en=1 and fifo_write_data=the accepted data for the cycle after edge t. Otherwise fifo_w_en=0 and data holds its last value.
- Occupancy next value = occupancy + transfer − (fifo_r_en && occupancy>0).
  - Simultaneous transfer and read leaves it unchanged.
  - Never exceeds DEPTH and never wraps below 0.
- At occupancy==DEPTH:
  - No grant is issued that cycle, even if fifo_r_en=1.
  - The returned credit is usable the next cycle. This is conservative and intentional.
- Ordering: beats from one requester reach the fifo in acceptance order. Bursts are never interleaved when BURST_MODE=1.
- Back-to-back beats: full throughput of one beat per cycle while credit is available.

Decomposition:
- Package fifo_arb_pkg holds:
  - arb_state_t enum {IDLE, BURST}.
  - Function rr_pick(valid, last_idx) returning the winner index and a found flag.
  - Localparam for the occupancy width.
- Sub-module rr_arbiter (pure combinational priority-rotate, N_REQ parameter) is natural and is reused by the planned read-side scheduler.

Test Plan (N_REQ=4, WIDTH=8, DEPTH=8, BURST_MODE=1, arbiter feeding a real fifo):
- Reset with valids high: hold reset=0 for 2 cycles while req_valid=4'b1111 -> req_ready=0, fifo_w_en=0, occupancy=0, grant_id=3 throughout.
- Round robin: req_valid=4'b1111, req_last=4'b1111, random data, 8 cycles -> grants in order 0,1,2,3,0,1,2,3; occupancy reaches 8; read-back order matches grant order.
- Full stall: at occupancy=8, req0 valid -> req_ready=0. Pulse fifo_r_en once -> occupancy=7, req_ready[0]=1 next cycle, that word is written, occupancy back to 8, fifo never overflows.
- Burst lock: req1 sends 3 beats (last on beat 3) while req2 is valid throughout -> req2 is granted only after req1's beat 3; fifo holds 1,1,1,2 in order.
- Simultaneous read/write at occupancy=4 -> occupancy stays 4; FIFO contents preserved in order.
- Reset mid-burst: assert reset=0 after beat 2 of 4 -> busy=0, occupancy=0, next IDLE grant starts at requester 0.
